// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: default datapath widths and the prefetch queue entry.
package cpu_pkg;

   localparam int IADDRWIDTH = 16;
   localparam int IWIDTH     = 16;

   typedef struct packed {
      logic [IADDRWIDTH-1:0] pc;
      logic [IWIDTH-1:0]     instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory port, instruction output stream and redirect.
interface fetch_unit_if #(
   parameter int IADDRWIDTH = cpu_pkg::IADDRWIDTH,
   parameter int IWIDTH     = cpu_pkg::IWIDTH
);
   logic [IADDRWIDTH-1:0] iaddr;
   logic                  ireq;
   logic [IWIDTH-1:0]     idata;
   logic                  out_valid;
   logic [IWIDTH-1:0]     out_instr;
   logic [IADDRWIDTH-1:0] out_pc;
   logic                  out_ready;
   logic                  redirect;
   logic [IADDRWIDTH-1:0] redirect_pc;

   modport master (
      output iaddr, ireq, out_valid, out_instr, out_pc,
      input  idata, out_ready, redirect, redirect_pc
   );

   modport slave (
      input  iaddr, ireq, out_valid, out_instr, out_pc,
      output idata, out_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/fifo_sync.sv
// Synchronous in-order FIFO; head is read straight out of the storage registers.
module fifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       valid,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [AW-1:0]               wr_ptr, rd_ptr;
   logic                        do_pop;

   assign valid  = (count != '0);
   assign full   = (count == CNTW'(DEPTH));
   assign do_pop = pop && valid;
   assign dout   = mem[rd_ptr];

   // Push and pop at full is fine: the slot being written is the one leaving.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, do_pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction prefetcher: credit-limited sequential fetch, fixed-latency return pipe,
// in-order prefetch queue and same-cycle redirect flush.
module fetch_unit #(
   parameter int IADDRWIDTH  = cpu_pkg::IADDRWIDTH,
   parameter int IWIDTH      = cpu_pkg::IWIDTH,
   parameter int DEPTH       = 4,
   parameter int MEM_LATENCY = 1
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);
   localparam int CW = $clog2(DEPTH + MEM_LATENCY + 1);
   localparam int QW = $clog2(DEPTH + 1);
   localparam int EW = IADDRWIDTH + IWIDTH;

   typedef struct packed {
      logic [IADDRWIDTH-1:0] pc;
      logic [IWIDTH-1:0]     instr;
   } entry_t;

   logic [IADDRWIDTH-1:0]                  fpc;
   logic [MEM_LATENCY:1]                   vld_pipe;
   logic [MEM_LATENCY:1][IADDRWIDTH-1:0]   adr_pipe;
   logic [CW-1:0]                          inflight;
   logic [QW-1:0]                          occupancy;
   logic                                   credit, push, pop, q_valid, q_full;
   entry_t                                 q_din, q_dout;

   always_comb begin
      inflight = '0;
      for (int i = 1; i <= MEM_LATENCY; i++)
         inflight = inflight + CW'(vld_pipe[i]);
   end

   // Returning fetches still hold credit, so the queue can never overflow.
   assign credit    = (CW'(occupancy) + inflight) < CW'(DEPTH);
   assign bus.ireq  = !rst && (bus.redirect || credit);
   assign bus.iaddr = bus.redirect ? bus.redirect_pc : fpc;

   // A redirect drops the return landing this cycle along with everything queued.
   assign push        = vld_pipe[MEM_LATENCY] && !bus.redirect;
   assign pop         = bus.out_ready && q_valid;
   assign q_din.pc    = adr_pipe[MEM_LATENCY];
   assign q_din.instr = bus.idata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpc      <= '0;
         vld_pipe <= '0;
         adr_pipe <= '0;
      end else begin
         if (bus.ireq)
            fpc <= bus.iaddr + IADDRWIDTH'(1);
         vld_pipe[1] <= bus.ireq;
         adr_pipe[1] <= bus.iaddr;
         for (int i = 2; i <= MEM_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1] && !bus.redirect;
            adr_pipe[i] <= adr_pipe[i-1];
         end
      end
   end

   fifo_sync #(.WIDTH(EW), .DEPTH(DEPTH)) u_queue (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.redirect),
      .push  (push),
      .din   (q_din),
      .pop   (pop),
      .dout  (q_dout),
      .valid (q_valid),
      .full  (q_full),
      .count (occupancy)
   );

   assign bus.out_valid = q_valid;
   assign bus.out_instr = q_dout.instr;
   assign bus.out_pc    = q_dout.pc;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && q_full && !pop));
endmodule
